// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared types, default sizes and helpers for the read side of the dual-clock FIFO.
package fifo_rd_ctrl_pkg;

  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] skid_occupancy(input skid_state_e s);
    case (s)
      SKID_ONE: return 2'd1;
      SKID_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_skid.sv
// Two-entry output skid buffer: head drives rd_data, tail absorbs one word of backpressure.
module fifo_rd_skid
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            count
);

  skid_state_e           state;
  logic [DATA_WIDTH-1:0] tail;
  logic                  pop;

  assign pop   = rd_valid & rd_ready;
  assign count = skid_occupancy(state);

  // An arrival while TWO without a pop cannot happen: the issuer keeps occupancy <= 2.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state    <= SKID_EMPTY;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      tail     <= '0;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_valid) begin
            rd_data  <= in_data;
            rd_valid <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_valid && !pop) begin
            tail  <= in_data;
            state <= SKID_TWO;
          end else if (in_valid && pop) begin
            rd_data <= in_data;
          end else if (pop) begin
            rd_valid <= 1'b0;
            state    <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (pop) begin
            rd_data <= tail;
            if (in_valid) begin
              tail <= in_data;
            end else begin
              state <= SKID_ONE;
            end
          end
        end
        default: begin
          state    <= SKID_EMPTY;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: pointers, empty/level flags and read issue.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [ADDR_WIDTH:0]   rd_wptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty,
  output logic [ADDR_WIDTH:0]   rd_level
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;

  logic [PTR_WIDTH-1:0] rptr_bin;
  logic [PTR_WIDTH-1:0] rptr_next;
  logic [PTR_WIDTH-1:0] rptr_next_gray;
  logic [PTR_WIDTH-1:0] wptr_bin;
  logic                 inflight;
  logic [1:0]           skid_count;
  logic [1:0]           occ;
  logic                 pop;

  always_comb begin
    wptr_bin = '0;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      wptr_bin[i] = ^(rd_wptr_gray >> i);
    end
  end

  assign pop            = rd_valid & rd_ready;
  assign occ            = skid_count + {1'b0, inflight};
  assign mem_rd_en      = !rd_empty && ((occ < 2'd2) || pop);
  assign mem_rd_addr    = rptr_bin[ADDR_WIDTH-1:0];
  assign rptr_next      = rptr_bin + {{ADDR_WIDTH{1'b0}}, mem_rd_en};
  assign rptr_next_gray = rptr_next ^ (rptr_next >> 1);

  // Flags are judged against the post-issue pointer so a stale empty can only hold reads back.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rptr_bin    <= '0;
      rd_ptr_gray <= '0;
      rd_empty    <= 1'b1;
      rd_level    <= '0;
      inflight    <= 1'b0;
    end else begin
      rptr_bin    <= rptr_next;
      rd_ptr_gray <= rptr_next_gray;
      rd_empty    <= (rptr_next_gray == rd_wptr_gray);
      rd_level    <= wptr_bin - rptr_next;
      inflight    <= mem_rd_en;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .rd_clk  (rd_clk),
    .rd_rst  (rd_rst),
    .in_valid(inflight),
    .in_data (mem_rd_data),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .count   (skid_count)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Self-checking bench for fifo_rd_ctrl with a registered RAM model and a word-queue scoreboard.
module tb_fifo_rd_ctrl;

  logic       rd_clk;
  logic       rd_rst;
  logic [4:0] rd_wptr_gray;
  logic [4:0] rd_ptr_gray;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_empty;
  logic [4:0] rd_level;

  logic [7:0] ram [16];
  int tests = 0;
  int fails = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .rd_clk      (rd_clk),
    .rd_rst      (rd_rst),
    .rd_wptr_gray(rd_wptr_gray),
    .rd_ptr_gray (rd_ptr_gray),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .rd_empty    (rd_empty),
    .rd_level    (rd_level)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = 5'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    rd_rst       = 1'b1;
    rd_wptr_gray = '0;
    rd_ready     = 1'b0;
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
    @(negedge rd_clk);
  endtask

  task automatic test_reset();
    rd_rst       = 1'b1;
    rd_wptr_gray = '0;
    rd_ready     = 1'b0;
    @(negedge rd_clk);
    tests++; if (rd_empty !== 1'b1) begin fails++; $display("[TB] FAIL reset_empty: got %0b expected 1", rd_empty); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", rd_valid); end
    tests++; if (rd_ptr_gray !== 5'b00000) begin fails++; $display("[TB] FAIL reset_ptr: got %b expected 00000", rd_ptr_gray); end
    tests++; if (mem_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
    tests++; if (rd_level !== 5'd0) begin fails++; $display("[TB] FAIL reset_level: got %0d expected 0", rd_level); end
    tests++; if (rd_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00", rd_data); end
    rd_rst = 1'b0;
    @(negedge rd_clk);
  endtask

  task automatic test_single_word();
    do_reset();
    ram[0] = 8'hA5;
    rd_wptr_gray = 5'b00001;
    @(negedge rd_clk);
    tests++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 4'd0) begin fails++; $display("[TB] FAIL single_issue: got en=%0b addr=%0d expected en=1 addr=0", mem_rd_en, mem_rd_addr); end
    @(negedge rd_clk);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_early_valid: got %0b expected 0", rd_valid); end
    @(negedge rd_clk);
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin fails++; $display("[TB] FAIL single_data: got valid=%0b data=%h expected valid=1 data=a5", rd_valid, rd_data); end
    tests++; if (rd_ptr_gray !== 5'b00001) begin fails++; $display("[TB] FAIL single_ptr: got %b expected 00001", rd_ptr_gray); end
    tests++; if (rd_empty !== 1'b1 || rd_level !== 5'd0) begin fails++; $display("[TB] FAIL single_flags: got empty=%0b level=%0d expected 1/0", rd_empty, rd_level); end
    rd_ready = 1'b1;
    @(negedge rd_clk);
    rd_ready = 1'b0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_drain: got valid=%0b expected 0", rd_valid); end
  endtask

  task automatic test_stream();
    int wait_cyc;
    do_reset();
    for (int i = 0; i < 16; i++) ram[i] = 8'(i);
    rd_ready = 1'b1;
    rd_wptr_gray = 5'b11000;
    wait_cyc = 0;
    while (!rd_valid && wait_cyc < 10) begin @(negedge rd_clk); wait_cyc++; end
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL stream_timeout: got valid=%0b expected 1", rd_valid); end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        fails++; $display("[TB] FAIL stream_word%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, rd_valid, rd_data, i);
      end
      @(negedge rd_clk);
    end
    repeat (2) @(negedge rd_clk);
    tests++; if (rd_valid !== 1'b0 || rd_empty !== 1'b1) begin fails++; $display("[TB] FAIL stream_end: got valid=%0b empty=%0b expected 0/1", rd_valid, rd_empty); end
    tests++; if (rd_ptr_gray !== 5'b11000) begin fails++; $display("[TB] FAIL stream_ptr: got %b expected 11000", rd_ptr_gray); end
    tests++; if (rd_level !== 5'd0) begin fails++; $display("[TB] FAIL stream_level: got %0d expected 0", rd_level); end
    rd_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses;
    do_reset();
    for (int i = 0; i < 8; i++) ram[i] = 8'(i);
    rd_ready = 1'b0;
    rd_wptr_gray = to_gray(8);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rd_clk);
      if (mem_rd_en === 1'b1) pulses++;
      if (c >= 4) begin
        tests++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
          fails++; $display("[TB] FAIL bp_hold%0d: got valid=%0b data=%h expected valid=1 data=00", c, rd_valid, rd_data);
        end
      end
    end
    tests++; if (pulses != 2) begin fails++; $display("[TB] FAIL bp_pulses: got %0d expected 2", pulses); end
    tests++; if (rd_level !== 5'd6) begin fails++; $display("[TB] FAIL bp_level: got %0d expected 6", rd_level); end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        fails++; $display("[TB] FAIL bp_release%0d: got valid=%0b data=%0d expected valid=1 data=%0d", i, rd_valid, rd_data, i);
      end
      @(negedge rd_clk);
    end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_drained: got valid=%0b expected 0", rd_valid); end
    rd_ready = 1'b0;
  endtask

  // Random bursty writer and random consumer; leaves both pointers at 30 for the wrap test.
  task automatic test_random_prefill();
    logic [7:0] q[$];
    logic [7:0] word;
    int wr;
    int popped;
    int cyc;
    do_reset();
    wr = 0; popped = 0; cyc = 0;
    while ((wr < 30 || q.size() > 0) && cyc < 2000) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      if (rd_valid && rd_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("[TB] FAIL rand_extra_word: got data=%h expected no word", rd_data);
        end else begin
          if (rd_data !== q[0]) begin
            fails++; $display("[TB] FAIL rand_word%0d: got %h expected %h", popped, rd_data, q[0]);
          end
          void'(q.pop_front());
        end
        popped++;
      end
      if (wr < 30 && (wr - popped) < 16 && $urandom_range(0, 1) == 1) begin
        word = 8'($urandom);
        ram[wr % 16] = word;
        q.push_back(word);
        wr++;
        rd_wptr_gray = to_gray(wr);
      end
      @(negedge rd_clk);
      cyc++;
    end
    tests++; if (cyc >= 2000) begin fails++; $display("[TB] FAIL rand_timeout: got %0d words left expected 0", q.size()); end
    rd_ready = 1'b0;
    repeat (2) @(negedge rd_clk);
    tests++; if (rd_ptr_gray !== to_gray(30) || rd_empty !== 1'b1) begin fails++; $display("[TB] FAIL rand_final: got ptr=%b empty=%0b expected ptr=%b empty=1", rd_ptr_gray, rd_empty, to_gray(30)); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    int addrs[$];
    logic [7:0] word;
    for (int k = 0; k < 4; k++) begin
      word = 8'($urandom);
      ram[(30 + k) % 16] = word;
      q.push_back(word);
    end
    rd_ready = 1'b1;
    rd_wptr_gray = to_gray(34);
    for (int c = 0; c < 12; c++) begin
      @(negedge rd_clk);
      if (mem_rd_en === 1'b1) addrs.push_back(int'(mem_rd_addr));
      if (rd_valid === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("[TB] FAIL wrap_extra_word: got data=%h expected no word", rd_data);
        end else begin
          if (rd_data !== q[0]) begin fails++; $display("[TB] FAIL wrap_word: got %h expected %h", rd_data, q[0]); end
          void'(q.pop_front());
        end
      end
    end
    tests++; if (addrs.size() != 4) begin fails++; $display("[TB] FAIL wrap_read_count: got %0d expected 4", addrs.size()); end
    for (int k = 0; k < 4 && k < addrs.size(); k++) begin
      tests++;
      if (addrs[k] != (30 + k) % 16) begin fails++; $display("[TB] FAIL wrap_addr%0d: got %0d expected %0d", k, addrs[k], (30 + k) % 16); end
    end
    tests++; if (q.size() != 0) begin fails++; $display("[TB] FAIL wrap_missing: got %0d words unread expected 0", q.size()); end
    tests++; if (rd_ptr_gray !== 5'b00011) begin fails++; $display("[TB] FAIL wrap_ptr: got %b expected 00011", rd_ptr_gray); end
    rd_ready = 1'b0;
  endtask

  task automatic test_midstream_reset();
    int wait_cyc;
    do_reset();
    for (int i = 0; i < 4; i++) ram[i] = 8'($urandom_range(1, 255));
    rd_ready = 1'b0;
    rd_wptr_gray = to_gray(4);
    wait_cyc = 0;
    while (!rd_valid && wait_cyc < 10) begin @(negedge rd_clk); wait_cyc++; end
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL mrst_setup: got valid=%0b expected 1", rd_valid); end
    rd_rst = 1'b1;
    #1;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL mrst_valid: got %0b expected 0", rd_valid); end
    tests++; if (rd_ptr_gray !== 5'b00000 || mem_rd_en !== 1'b0) begin fails++; $display("[TB] FAIL mrst_ptr: got ptr=%b en=%0b expected 00000/0", rd_ptr_gray, mem_rd_en); end
    rd_wptr_gray = '0;
    repeat (2) @(negedge rd_clk);
    rd_rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge rd_clk);
      tests++;
      if (rd_valid !== 1'b0 || rd_ptr_gray !== 5'b00000) begin
        fails++; $display("[TB] FAIL mrst_stale%0d: got valid=%0b ptr=%b expected 0/00000", c, rd_valid, rd_ptr_gray);
      end
    end
    ram[0] = 8'h3C;
    rd_wptr_gray = to_gray(1);
    repeat (3) @(negedge rd_clk);
    tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin fails++; $display("[TB] FAIL mrst_recover: got valid=%0b data=%h expected 1/3c", rd_valid, rd_data); end
  endtask

  initial begin
    rd_rst       = 1'b1;
    rd_wptr_gray = '0;
    rd_ready     = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = '0;
    test_reset();
    test_single_word();
    test_stream();
    test_backpressure();
    test_random_prefill();
    test_wrap();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
